// File: rtl/genius_autoplayer.sv
// Genius autoplayer: captures the game's digit display and replays it on the button bus.
// Define GENIUS_AUTOPLAY_FAULT_EN to add fault_arm/fault_idx for deliberate wrong presses.
module genius_autoplayer #(
    parameter int DEPTH         = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int PRESS_CYCLES  = 1,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] segd0,
`ifdef GENIUS_AUTOPLAY_FAULT_EN
    input  logic       fault_arm,
    input  logic [3:0] fault_idx,
`endif
    output logic [2:0] btn,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] seq_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SETTLE,
        S_PRESS,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [4:0] DEPTH_L  = 5'(DEPTH);
    localparam logic [7:0] SETTLE_L = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] PRESS_L  = 8'(PRESS_CYCLES - 1);
    localparam logic [7:0] GAP_L    = 8'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [4:0] len_q, len_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] btn_q, btn_d;
    logic       busy_q, done_q, error_q;
    logic [1:0] buf_q [DEPTH];

    logic       dig_valid;
    logic       dig_blank;
    logic [1:0] dig;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [2:0] code;

    always_comb begin
        dig_valid = 1'b1;
        dig_blank = 1'b0;
        dig       = 2'd0;
        unique case (segd0)
            7'h3F:   dig = 2'd0;
            7'h06:   dig = 2'd1;
            7'h5B:   dig = 2'd2;
            7'h4F:   dig = 2'd3;
            7'h00: begin
                dig_valid = 1'b0;
                dig_blank = 1'b1;
            end
            default: dig_valid = 1'b0;
        endcase
    end

    // IDLE writes slot 0; CAPTURE appends at the current length.
    assign wr_idx = (state_q == S_IDLE) ? 4'd0 : len_q[3:0];

    always_comb begin
        code = {1'b0, buf_q[idx_q]} + 3'd1;
`ifdef GENIUS_AUTOPLAY_FAULT_EN
        if (fault_arm && (idx_q == fault_idx)) begin
            code = {1'b0, code[1:0]} + 3'd1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (dig_valid) begin
                        wr_en   = 1'b1;
                        len_d   = 5'd1;
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (dig_blank) begin
                        cnt_d   = 8'd0;
                        state_d = S_SETTLE;
                    end else if (!dig_valid || len_q == DEPTH_L) begin
                        state_d = S_ERROR;
                    end else begin
                        wr_en = 1'b1;
                        len_d = len_q + 5'd1;
                    end
                end
                S_SETTLE: begin
                    if (dig_valid) begin
                        state_d = S_ERROR;
                    end else if (cnt_q == SETTLE_L) begin
                        cnt_d   = 8'd0;
                        idx_d   = 4'd0;
                        state_d = S_PRESS;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_PRESS: begin
                    if (cnt_q == PRESS_L) begin
                        cnt_d   = 8'd0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_L) begin
                        cnt_d = 8'd0;
                        if ({1'b0, idx_q} < len_q - 5'd1) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_PRESS;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Button lags the state that selects it by one cycle.
    always_comb begin
        btn_d = 3'd0;
        if (enable && state_q == S_PRESS) begin
            btn_d = code;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= 5'd0;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            btn_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= enable && (state_q == S_DONE);
            error_q <= (state_d == S_ERROR);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_q[wr_idx] <= dig;
        end
    end

    assign btn     = btn_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign seq_len = len_q;

endmodule

// File: doc/genius_autoplayer.md
Name: genius_autoplayer

Overview:
- Automatic player for the Genius game: the opposite end of the game's display/button interface.
- Watches the game's digit display (segd0), decodes and buffers the shown sequence, then replays it on the 3-bit button bus with configurable press/gap timing.
- Used for self-test and demo: connects to the game in place of the human player.

Parameters:
- DEPTH, 16, max sequence entries buffered (power of two, ≤16).
- SETTLE_CYCLES, 2, idle cycles between end of display and first press (1..255).
- PRESS_CYCLES, 1, cycles each button code is held (1..255); the game counts a press every cycle it is held.
- GAP_CYCLES, 1, cycles btn=0 between presses (1..255).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-low
- enable  input  1  1 = autoplayer active; 0 = forced to IDLE, btn released
- segd0  input  7  game digit display, active-high segments {g,f,e,d,c,b,a}; 7'h00 = blank
- btn  output  3  button code: 3'b000 = no press, else value n encoded as n+1 (3'd1..3'd4)
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after the last press's gap completes
- error  output  1  sticky until reset, or until enable goes low
- seq_len  output  5  entries captured in the current round (0..DEPTH)

Behaviour:
- Reset (reset=0 at posedge): state=IDLE, btn=0, busy=0, done=0, error=0, seq_len=0, all counters 0. Reset dominates enable.
- Segment decode (combinational, registered into buffer): 7'h3F→0, 7'h06→1, 7'h5B→2, 7'h4F→3, 7'h00→blank; any other value is invalid.
- IDLE: btn=0. If enable=1 and segd0 is a valid digit → write digit to buf[0], seq_len=1, go CAPTURE (the sample is taken in the same cycle).
- CAPTURE: each cycle, a valid digit → buf[seq_len], seq_len+1. Identical consecutive digits are separate entries (one entry per clock). Blank → go SETTLE with counter=0.
  - Invalid pattern → ERROR.
  - Valid digit when seq_len==DEPTH → ERROR (overflow).
- SETTLE: btn=0, count SETTLE_CYCLES. A valid digit during SETTLE → ERROR. On expiry: idx=0, go PRESS.
- PRESS: btn=buf[idx]+1 for PRESS_CYCLES cycles → GAP.
- GAP: btn=0 for GAP_CYCLES cycles. Then:
  - idx<seq_len-1 → idx+1, go PRESS.
  - Otherwise → go DONE.
- DONE: done=1 for exactly this cycle, seq_len holds, → IDLE. The next round is captured from the next non-blank segd0.
- ERROR: btn=0, busy=1, error=1. Exits only by reset or enable=0.
- enable=0 in any state: next cycle state=IDLE, btn=0, error=0, seq_len holds its last value. Buffer contents are don't-care.
- All outputs are registered. btn changes one cycle after the state/counter edge that selects it.
- Round timing, for seq_len L and defaults: first press on cycle 1+SETTLE after the blank is detected; total replay is L·(PRESS+GAP) cycles.

Optional Feature:
- Macro GENIUS_AUTOPLAY_FAULT_EN.
- With the macro: extra input ports fault_arm (1 bit) and fault_idx (4 bits).
  - During replay, if fault_arm=1 and idx==fault_idx, btn=((buf[idx]+1) mod 4)+1, i.e. a deliberately wrong button.
  - The autoplayer still proceeds through the remaining entries; the game is expected to reset.
- Without the macro: those ports do not exist and replay is always the captured value.

Test Plan:
- Reset: reset=0 for 2 cycles with enable=1 and segd0=7'h06 → btn=0, busy=0, error=0, seq_len=0; after release the first sample is captured.
- Single entry: segd0 = 7'h5B for 1 cycle then 7'h00 → seq_len=1, after 2 SETTLE cycles btn=3'd3 for 1 cycle, btn=0 for 1 cycle, done pulses once.
- Repeat digits: segd0 = 3F,3F,4F,06 then 00 → seq_len=4; btn sequence 1,0,1,0,4,0,2,0; done=1 the cycle after the final gap.
- Boundaries:
  - 17 consecutive valid digits → error=1 on the 17th, btn stays 0.
  - segd0=7'h7F in CAPTURE → error=1.
  - enable 1→0 → error clears next cycle.
- Abort: drop enable mid-PRESS in a 3-entry replay → btn=0 and busy=0 on the next cycle; re-enable and show 7'h06,00 → clean single-entry replay.
- Fault (GENIUS_AUTOPLAY_FAULT_EN): fault_arm=1, fault_idx=1, sequence 0,2 → btn presses 1 then 4, not 3; done still pulses.
